// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution window generator.
//   PIX_W       : default pixel width in bits
//   WIN_N       : window edge length (3x3 window)
//   SLOT_RxCy   : slot index of window element (dr=x, dc=y) in the packed bus;
//                 dr/dc = 0 is the oldest row/column (r-2 / c-2), 2 is (r / c)
//   ST_*        : state encoding of the frame FSM
package conv_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_N = 3;

  localparam int unsigned SLOT_R0C0 = 0;
  localparam int unsigned SLOT_R0C1 = 1;
  localparam int unsigned SLOT_R0C2 = 2;
  localparam int unsigned SLOT_R1C0 = 3;
  localparam int unsigned SLOT_R1C1 = 4;
  localparam int unsigned SLOT_R1C2 = 5;
  localparam int unsigned SLOT_R2C0 = 6;
  localparam int unsigned SLOT_R2C1 = 7;
  localparam int unsigned SLOT_R2C2 = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/conv_line_buf.sv
// One image line of storage, indexed by column.
//   clk   : clock
//   we    : write enable
//   addr  : column index (shared by read and write)
//   wdata : value stored at addr on the rising edge when we=1
//   rdata : combinational read of addr; returns the value before this cycle's write
module conv_line_buf #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the consumer gates on its own counters.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Builds 3x3 valid-padding windows from a raster-order pixel stream.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   i_start  : arms a new frame (only honoured in IDLE)
//   i_valid  : i_pixel valid this cycle
//   i_pixel  : input pixel, raster order
//   o_tensor : packed window, slot (dr,dc) at [(3*dr+dc)*PIX_W +: PIX_W]
//   o_valid  : one-cycle pulse, o_tensor valid
//   o_busy   : high while streaming a frame
//   o_done   : one-cycle pulse coinciding with the last window of a frame
module conv_window_gen #(
  parameter int unsigned PIX_W = conv_pkg::PIX_W,
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic [PIX_W-1:0]   i_pixel,
  output logic [9*PIX_W-1:0] o_tensor,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done
);

  import conv_pkg::*;

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             accept_c;
  logic             last_col_c;
  logic             win_valid_c;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] win_q [WIN_N][WIN_N];
  logic [PIX_W-1:0] win_d [WIN_N][WIN_N];
  logic [9*PIX_W-1:0] tensor_d;

  assign accept_c    = (state_q == ST_STREAM) && i_valid;
  assign last_col_c  = (col_q == COL_W'(IMG_W - 1));
  // Column gate keeps windows from straddling a row wrap.
  assign win_valid_c = accept_c && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // LB0 holds row r-1; LB1 is fed from LB0 and holds row r-2.
  conv_line_buf #(.WIDTH(PIX_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb0 (
    .clk   (clk),
    .we    (accept_c),
    .addr  (col_q),
    .wdata (i_pixel),
    .rdata (lb0_rd)
  );

  conv_line_buf #(.WIDTH(PIX_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb1 (
    .clk   (clk),
    .we    (accept_c),
    .addr  (col_q),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // State and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_STREAM;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_STREAM: begin
        if (accept_c) begin
          if (last_col_c) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            if (row_q == ROW_W'(IMG_H - 1)) state_d = ST_DONE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Window shift: new rightmost column is {r-2, r-1, r}.
  always_comb begin
    win_d = win_q;
    if (accept_c) begin
      for (int dr = 0; dr < int'(WIN_N); dr++) begin
        win_d[dr][0] = win_q[dr][1];
        win_d[dr][1] = win_q[dr][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = i_pixel;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  // Pack the post-shift window so the output reflects the accepted pixel.
  always_comb begin
    tensor_d = '0;
    tensor_d[SLOT_R0C0*PIX_W +: PIX_W] = win_d[0][0];
    tensor_d[SLOT_R0C1*PIX_W +: PIX_W] = win_d[0][1];
    tensor_d[SLOT_R0C2*PIX_W +: PIX_W] = win_d[0][2];
    tensor_d[SLOT_R1C0*PIX_W +: PIX_W] = win_d[1][0];
    tensor_d[SLOT_R1C1*PIX_W +: PIX_W] = win_d[1][1];
    tensor_d[SLOT_R1C2*PIX_W +: PIX_W] = win_d[1][2];
    tensor_d[SLOT_R2C0*PIX_W +: PIX_W] = win_d[2][0];
    tensor_d[SLOT_R2C1*PIX_W +: PIX_W] = win_d[2][1];
    tensor_d[SLOT_R2C2*PIX_W +: PIX_W] = win_d[2][2];
  end

  // Registered outputs; busy/done track the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_tensor <= '0;
    end else begin
      o_valid <= win_valid_c;
      o_busy  <= (state_d == ST_STREAM);
      o_done  <= (state_d == ST_DONE);
      if (win_valid_c) o_tensor <= tensor_d;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_valid, a_ovalid, a_busy, a_done;
  logic [7:0]  a_pix;
  logic [71:0] a_tensor;
  logic        b_start, b_valid, b_ovalid, b_busy, b_done;
  logic [7:0]  b_pix;
  logic [71:0] b_tensor;

  conv_window_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_valid(a_valid), .i_pixel(a_pix),
    .o_tensor(a_tensor), .o_valid(a_ovalid), .o_busy(a_busy), .o_done(a_done)
  );

  conv_window_gen #(.PIX_W(8), .IMG_W(5), .IMG_H(3)) u_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_valid(b_valid), .i_pixel(b_pix),
    .o_tensor(b_tensor), .o_valid(b_ovalid), .o_busy(b_busy), .o_done(b_done)
  );

  typedef struct {
    logic [71:0] t;
    bit          done;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Hand-computed windows: 4x4 frame (pixels 10,11,14,15) and 5x3 frame (12,13,14).
  logic [71:0] exp_a [4] = '{72'h0A_09_08_06_05_04_02_01_00,
                             72'h0B_0A_09_07_06_05_03_02_01,
                             72'h0E_0D_0C_0A_09_08_06_05_04,
                             72'h0F_0E_0D_0B_0A_09_07_06_05};
  int          idx_a [4] = '{10, 11, 14, 15};
  logic [71:0] exp_b [3] = '{72'h0C_0B_0A_07_06_05_02_01_00,
                             72'h0D_0C_0B_08_07_06_03_02_01,
                             72'h0E_0D_0C_09_08_07_04_03_02};
  int          idx_b [3] = '{12, 13, 14};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop and compare whenever a DUT presents a window.
  always @(negedge clk) begin
    exp_t e;
    if (a_ovalid) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 72'(a_ovalid), 72'(0));
      else begin
        e = qa.pop_front();
        chk("a_tensor", a_tensor, e.t);
        chk("a_done", 72'(a_done), 72'(e.done));
        chk("a_latency_cycle", 72'(cyc), 72'(e.cyc));
        if (e.done) chk("a_busy_at_done", 72'(a_busy), 72'(0));
      end
    end else if (a_done) chk("a_stray_done", 72'(a_done), 72'(0));
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_ovalid) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 72'(b_ovalid), 72'(0));
      else begin
        e = qb.pop_front();
        chk("b_tensor", b_tensor, e.t);
        chk("b_done", 72'(b_done), 72'(e.done));
        chk("b_latency_cycle", 72'(cyc), 72'(e.cyc));
        if (e.done) chk("b_busy_at_done", 72'(b_busy), 72'(0));
      end
    end else if (b_done) chk("b_stray_done", 72'(b_done), 72'(0));
  end

  task automatic drive(input bit sel, input bit st, input bit v, input logic [7:0] p);
    if (sel) begin b_start = st; b_valid = v; b_pix = p; end
    else     begin a_start = st; a_valid = v; a_pix = p; end
    @(posedge clk); #1;
  endtask

  task automatic push(input bit sel, input logic [71:0] t, input bit done);
    exp_t e;
    e.t = t; e.done = done; e.cyc = cyc + 1;
    if (sel) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic drain(input bit sel);
    for (int i = 0; i < 20; i++) begin
      if ((sel ? qb.size() : qa.size()) == 0) break;
      @(posedge clk);
    end
    #1;
    chk(sel ? "b_drain" : "a_drain", 72'(sel ? qb.size() : qa.size()), 72'(0));
  endtask

  task automatic start(input bit sel);
    drive(sel, 1'b1, 1'b0, 8'h00);
    chk(sel ? "b_busy_after_start" : "a_busy_after_start", 72'(sel ? b_busy : a_busy), 72'(1));
  endtask

  task automatic run_frame(input bit sel, input bit gap, input int mid_start, input int npix);
    int nexp;
    int k;
    nexp = sel ? 3 : 4;
    k = 0;
    for (int p = 0; p < npix; p++) begin
      if (k < nexp && p == (sel ? idx_b[k] : idx_a[k])) begin
        push(sel, sel ? exp_b[k] : exp_a[k], k == nexp - 1);
        k++;
      end
      drive(sel, p == mid_start, 1'b1, 8'(p));
      if (gap) drive(sel, 1'b0, 1'b0, 8'hA5);
    end
    drive(sel, 1'b0, 1'b0, 8'h00);
    drain(sel);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_a_valid"},  72'(a_ovalid), 72'(0));
    chk({tag, "_a_done"},   72'(a_done),   72'(0));
    chk({tag, "_a_busy"},   72'(a_busy),   72'(0));
    chk({tag, "_a_tensor"}, a_tensor,      72'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_pix = 8'h00;
    b_start = 1'b0; b_valid = 1'b0; b_pix = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_a("reset");
    chk("reset_b_valid",  72'(b_ovalid), 72'(0));
    chk("reset_b_done",   72'(b_done),   72'(0));
    chk("reset_b_busy",   72'(b_busy),   72'(0));
    chk("reset_b_tensor", b_tensor,      72'(0));
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Back-to-back 4x4 frame.
    start(1'b0);
    run_frame(1'b0, 1'b0, -1, 16);
    chk("a_busy_after_frame", 72'(a_busy), 72'(0));

    // Same frame with a bubble after every pixel.
    start(1'b0);
    run_frame(1'b0, 1'b1, -1, 16);

    // Pixels offered while idle must be dropped.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'hE0 + 8'(i));
    start(1'b0);
    run_frame(1'b0, 1'b0, -1, 16);

    // Reset mid-frame after pixel 11, then a clean frame.
    start(1'b0);
    run_frame(1'b0, 1'b0, -1, 12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero_a("midreset");
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 8'(i));
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    start(1'b0);
    run_frame(1'b0, 1'b0, -1, 16);

    // Non-square 5x3 frame.
    start(1'b1);
    run_frame(1'b1, 1'b0, -1, 15);

    // i_start pulsed mid-stream must be ignored.
    start(1'b0);
    run_frame(1'b0, 1'b0, 5, 16);

    repeat (3) @(posedge clk);
    #1;
    chk("a_final_queue", 72'(qa.size()), 72'(0));
    chk("b_final_queue", 72'(qb.size()), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
